odd_seq_monitor: RTL and testbench

- Downstream consumer of the free-running odd counter's 8-bit count.
- Samples the count when enabled and checks that it is odd and advances by exactly +2, wrapping from 2^WIDTH-1 to 1.
- Acquires lock after a run of good samples and counts errors and wraps.
- Exposes status for a debug/CSR block.

---
 rtl/odd_seq_monitor_if.sv | 30 +++
 rtl/odd_seq_monitor.sv | 139 +++++++++++++
 tb/tb_odd_seq_monitor.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/odd_seq_monitor_if.sv
// Bundle of sample inputs and status outputs between the odd-counter monitor
// and its driver/observer (source side plus debug/CSR block).
interface odd_seq_monitor_if #(
  parameter int WIDTH  = 8,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 16
);
  logic              en;
  logic [WIDTH-1:0]  count;
  logic              clr;
  logic              locked;
  logic              err_pulse;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WIDTH-1:0]  last_bad;
  logic [WIDTH-1:0]  exp_out;

  // Source / CSR side: drives the sample strobe, count and clear.
  modport master (
    output en, count, clr,
    input  locked, err_pulse, err_sticky, err_cnt, wrap_cnt, last_bad, exp_out
  );

  // Monitor side.
  modport slave (
    input  en, count, clr,
    output locked, err_pulse, err_sticky, err_cnt, wrap_cnt, last_bad, exp_out
  );
endinterface

// File: rtl/odd_seq_monitor.sv
// Monitors an odd-only counter that should advance by +2 (mod 2^WIDTH).
// Acquires lock after LOCK_CNT consecutive good samples, counts bad samples
// (saturating) and good wraps through 1 (rolling), and records the last bad value.
module odd_seq_monitor #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  odd_seq_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  // LOCK_CNT is at most 255, so an 8-bit run length always suffices.
  localparam int RUN_W = 8;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [RUN_W-1:0]   run_inc;
  logic               ok;
  logic               bad;
  logic               wrap;

  logic               locked_q;
  logic               err_pulse_q;
  logic               err_sticky_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic [WRAP_W-1:0]  wrap_cnt_q;
  logic [WIDTH-1:0]   last_bad_q;

  assign ok      = (bus.count == exp_q);
  assign run_inc = run_q + RUN_W'(1);

  // Next-state and next-expectation logic for the sampling FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    bad     = 1'b0;
    wrap    = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        IDLE: begin
          if (bus.count[0]) begin
            exp_d   = bus.count + WIDTH'(2);
            run_d   = RUN_W'(1);
            state_d = ACQ;
          end else begin
            bad = 1'b1;
          end
        end
        ACQ, LOCK: begin
          if (ok) begin
            exp_d = exp_q + WIDTH'(2);
            wrap  = (bus.count == WIDTH'(1));
            if (state_q == ACQ) begin
              run_d = run_inc;
              if (run_inc == RUN_W'(LOCK_CNT)) state_d = LOCK;
            end
          end else begin
            bad = 1'b1;
            // Resync: an odd value seeds a fresh acquisition, an even one drops to IDLE.
            if (bus.count[0]) begin
              exp_d   = bus.count + WIDTH'(2);
              run_d   = RUN_W'(1);
              state_d = ACQ;
            end else begin
              run_d   = '0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          run_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM state, expectation and run length registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      exp_q   <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      run_q   <= run_d;
    end
  end

  // Registered status: lock flag, error reporting and counters (clr wins over increments).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
      wrap_cnt_q   <= '0;
      last_bad_q   <= '0;
    end else begin
      locked_q    <= (state_d == LOCK);
      err_pulse_q <= bad;
      if (bad) last_bad_q <= bus.count;
      if (bus.clr) begin
        err_sticky_q <= 1'b0;
        err_cnt_q    <= '0;
        wrap_cnt_q   <= '0;
      end else begin
        if (bad) err_sticky_q <= 1'b1;
        if (bad && (err_cnt_q != {ERR_W{1'b1}})) err_cnt_q <= err_cnt_q + ERR_W'(1);
        if (wrap) wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.wrap_cnt   = wrap_cnt_q;
  assign bus.last_bad   = last_bad_q;
  assign bus.exp_out    = exp_q;

endmodule

// File: tb/tb_odd_seq_monitor.sv
// Directed bench for odd_seq_monitor: a vector table for the main sequence,
// plus hand-written wrap, saturation, clear and mid-lock reset sequences.
module tb_odd_seq_monitor;
  localparam int WIDTH    = 8;
  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int WRAP_W   = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  odd_seq_monitor_if #(.WIDTH(WIDTH), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) bus ();

  odd_seq_monitor #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W), .WRAP_W(WRAP_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        en;
    logic [7:0]  count;
    logic        clr;
    logic        locked;
    logic        pulse;
    logic        sticky;
    logic [7:0]  err;
    logic [15:0] wrap;
    logic [7:0]  last_bad;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".locked"},   32'(bus.locked),     32'(v.locked));
    check({tag, ".pulse"},    32'(bus.err_pulse),  32'(v.pulse));
    check({tag, ".sticky"},   32'(bus.err_sticky), 32'(v.sticky));
    check({tag, ".err_cnt"},  32'(bus.err_cnt),    32'(v.err));
    check({tag, ".wrap_cnt"}, 32'(bus.wrap_cnt),   32'(v.wrap));
    check({tag, ".last_bad"}, 32'(bus.last_bad),   32'(v.last_bad));
    check({tag, ".exp_out"},  32'(bus.exp_out),    32'(v.exp));
  endtask

  // Apply one cycle of inputs and return 1 time unit after the active edge.
  task automatic step(input logic en, input logic [7:0] count, input logic clr);
    bus.en    = en;
    bus.count = count;
    bus.clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string prefix);
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].count, tbl[i].clr);
      check_all($sformatf("%s%0d(cnt=%0d)", prefix, i, tbl[i].count), tbl[i]);
    end
    tbl.delete();
  endtask

  // Fields: en, count, clr -> locked, pulse, sticky, err, wrap, last_bad, exp
  function automatic void add(input logic en, input logic [7:0] count, input logic clr,
                              input logic locked, input logic pulse, input logic sticky,
                              input logic [7:0] err, input logic [15:0] wrap,
                              input logic [7:0] last_bad, input logic [7:0] exp);
    vec_t v;
    v = '{en, count, clr, locked, pulse, sticky, err, wrap, last_bad, exp};
    tbl.push_back(v);
  endfunction

  vec_t zero_v;
  logic pulse_seen;

  initial begin
    zero_v = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0, 8'd0, 8'd0};
    bus.en = 1'b0; bus.count = '0; bus.clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1 check_all("reset", zero_v);

    // Ideal source 1..9, error while locked, clr, even error, re-acquire, en gap.
    add(1,  1, 0,  0, 0, 0, 0, 0, 0,  3);   // IDLE -> ACQ, no wrap from IDLE
    add(1,  3, 0,  0, 0, 0, 0, 0, 0,  5);
    add(1,  5, 0,  0, 0, 0, 0, 0, 0,  7);
    add(1,  7, 0,  1, 0, 0, 0, 0, 0,  9);   // 4th good sample -> LOCK
    add(1,  9, 0,  1, 0, 0, 0, 0, 0, 11);
    add(1,  9, 0,  0, 1, 1, 1, 0, 9, 11);   // odd bad: resync, exp = 9+2
    add(1, 11, 0,  0, 0, 1, 1, 0, 9, 13);
    add(1, 13, 0,  0, 0, 1, 1, 0, 9, 15);
    add(1, 15, 1,  1, 0, 0, 0, 0, 9, 17);   // relock; clr zeroes counters
    add(1,  8, 0,  0, 1, 1, 1, 0, 8, 17);   // even bad: IDLE, exp held
    add(1,  7, 0,  0, 0, 1, 1, 0, 8,  9);
    add(1,  9, 0,  0, 0, 1, 1, 0, 8, 11);
    add(1, 11, 0,  0, 0, 1, 1, 0, 8, 13);
    add(1, 13, 0,  1, 0, 1, 1, 0, 8, 15);
    add(0, 15, 0,  1, 0, 1, 1, 0, 8, 15);   // en gap: everything holds
    add(0, 15, 0,  1, 0, 1, 1, 0, 8, 15);
    add(0, 15, 0,  1, 0, 1, 1, 0, 8, 15);
    add(1, 15, 0,  1, 0, 1, 1, 0, 8, 17);
    add(1, 17, 0,  1, 0, 1, 1, 0, 8, 19);
    run_table("t1_");

    // Run the source up through 255 and wrap to 1, 3.
    pulse_seen = 1'b0;
    for (int c = 19; c <= 255; c += 2) begin
      step(1'b1, 8'(c), 1'b0);
      pulse_seen |= bus.err_pulse;
    end
    check("pre_wrap.wrap_cnt", 32'(bus.wrap_cnt), 0);
    check("pre_wrap.exp_out",  32'(bus.exp_out),  1);
    step(1'b1, 8'd1, 1'b0);
    pulse_seen |= bus.err_pulse;
    check("wrap.wrap_cnt", 32'(bus.wrap_cnt), 1);
    check("wrap.exp_out",  32'(bus.exp_out),  3);
    step(1'b1, 8'd3, 1'b0);
    pulse_seen |= bus.err_pulse;
    check("wrap.locked",   32'(bus.locked),   1);
    check("wrap.err_cnt",  32'(bus.err_cnt),  1);
    check("wrap.pulses",   32'(pulse_seen),   0);

    // Even bad from LOCK, then an odd bad while in ACQ, relock, clr with en=0.
    add(1,  4, 0,  0, 1, 1, 2, 1,  4,  5);
    add(1, 21, 0,  0, 0, 1, 2, 1,  4, 23);
    add(1, 25, 0,  0, 1, 1, 3, 1, 25, 27);  // bad in ACQ, resync from 25
    add(1, 27, 0,  0, 0, 1, 3, 1, 25, 29);
    add(1, 29, 0,  0, 0, 1, 3, 1, 25, 31);
    add(1, 31, 0,  1, 0, 1, 3, 1, 25, 33);
    add(0,  0, 1,  1, 0, 0, 0, 0, 25, 33);  // clr acts with en=0; FSM holds
    run_table("t2_");

    // 300 bad samples: error counter saturates at all-ones.
    for (int i = 0; i < 300; i++) step(1'b1, 8'd0, 1'b0);
    check("sat.err_cnt",  32'(bus.err_cnt),    255);
    check("sat.sticky",   32'(bus.err_sticky), 1);
    check("sat.locked",   32'(bus.locked),     0);
    check("sat.exp_out",  32'(bus.exp_out),    33);

    // clr together with a bad sample: clear wins, pulse and last_bad still update.
    step(1'b1, 8'd2, 1'b1);
    check("clr_bad.err_cnt",  32'(bus.err_cnt),    0);
    check("clr_bad.sticky",   32'(bus.err_sticky), 0);
    check("clr_bad.pulse",    32'(bus.err_pulse),  1);
    check("clr_bad.last_bad", 32'(bus.last_bad),   2);
    step(1'b0, 8'd2, 1'b0);
    check("idle_gap.pulse",   32'(bus.err_pulse),  0);

    // Lock again, then reset mid-cycle: outputs drop before any clock edge.
    step(1'b1, 8'd1, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    step(1'b1, 8'd5, 1'b0);
    step(1'b1, 8'd7, 1'b0);
    check("relock.locked",  32'(bus.locked),  1);
    check("relock.exp_out", 32'(bus.exp_out), 9);
    #2 reset = 1'b1;
    #1 check_all("async_reset", zero_v);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 8'd5, 1'b0);
    check("post_reset.locked",  32'(bus.locked),  0);
    check("post_reset.exp_out", 32'(bus.exp_out), 7);
    check("post_reset.err_cnt", 32'(bus.err_cnt), 0);
    step(1'b1, 8'd7, 1'b0);
    step(1'b1, 8'd9, 1'b0);
    check("post_reset.run3_locked", 32'(bus.locked), 0);
    step(1'b1, 8'd11, 1'b0);
    check("post_reset.relock", 32'(bus.locked), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
